// File: rtl/fifo_read_stream.sv
// Read-side drain stage for asyncfifo: turns the r_en/empty/data_out port into a valid/ready stream
// through a 2-entry prefetch buffer. Optional transfer counter: FIFO_READ_STREAM_XFER_COUNT_EN.
module fifo_read_stream #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [1:0]            occupancy
`ifdef FIFO_READ_STREAM_XFER_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] xfer_count
`endif
);

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  logic                  inflight;
  logic [DATA_WIDTH-1:0] tail_q;
  logic                  pop;
  logic                  capture;
  logic [2:0]            credit;
  logic [1:0]            occ_next;
  logic [DATA_WIDTH-1:0] head_next;
  logic [DATA_WIDTH-1:0] tail_next;

  assign pop     = m_valid & m_ready;
  assign capture = inflight;

  // Words held plus words already requested, after this cycle's pop; 3 bits so 2+1 cannot wrap.
  assign credit    = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_r_en = ~rrst & ~fifo_empty & (credit < 3'd2);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    occ_next  = occupancy;
    head_next = m_data;
    tail_next = tail_q;
    case (occupancy)
      OCC_EMPTY: begin
        if (capture) begin
          occ_next  = OCC_ONE;
          head_next = fifo_data;
        end
      end
      OCC_ONE: begin
        if (capture && !pop) begin
          occ_next  = OCC_TWO;
          tail_next = fifo_data;
        end else if (!capture && pop) begin
          occ_next = OCC_EMPTY;
        end else if (capture && pop) begin
          head_next = fifo_data;
        end
      end
      OCC_TWO: begin
        // The credit rule keeps capture from landing here, but shifting still keeps order if it did.
        if (pop) begin
          head_next = tail_q;
          if (capture) tail_next = fifo_data;
          else         occ_next  = OCC_ONE;
        end
      end
      default: occ_next = OCC_EMPTY;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      occupancy <= OCC_EMPTY;
      m_valid   <= 1'b0;
      m_data    <= '0;
      inflight  <= 1'b0;
    end else begin
      occupancy <= occ_next;
      m_valid   <= (occ_next != OCC_EMPTY);
      m_data    <= head_next;
      inflight  <= fifo_r_en;
    end
  end

  // NOTE: the tail slot is pure storage qualified by occupancy, so it carries no reset.
  always_ff @(posedge rclk) begin
    tail_q <= tail_next;
  end

`ifdef FIFO_READ_STREAM_XFER_COUNT_EN
  always_ff @(posedge rclk) begin
    if (rrst) begin
      xfer_count <= '0;
    end else if (pop) begin
      xfer_count <= xfer_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end
`else
  if (COUNT_WIDTH < 1) begin : g_count_width_check
    $error("COUNT_WIDTH must be at least 1");
  end
`endif

endmodule
